// File: rtl/ring_seq_ctrl.sv
// One-hot ring sequencer: walks a slot pointer under a valid/ready handshake,
// with programmable pass count, pause/resume and abort.
module ring_seq_ctrl #(
  parameter int N       = 13,
  parameter int LOOPS_W = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               STOP,
  input  logic [LOOPS_W-1:0] LOOPS,
  input  logic               READY,
  output logic [N-1:0]       Q,
  output logic               VALID,
  output logic               LAST,
  output logic               BUSY,
  output logic               DONE,
  output logic [LOOPS_W-1:0] PASS
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       q_q, q_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LOOPS_W-1:0] pass_q, pass_d;
  logic [LOOPS_W-1:0] loops_q, loops_d;

  logic               xfer;
  logic               end_of_pass;
  logic               final_xfer;
  logic [LOOPS_W-1:0] pass_inc;

  assign xfer        = valid_q & READY;
  assign end_of_pass = xfer & q_q[N-1];
  assign pass_inc    = pass_q + LOOPS_W'(1);
  // A programmed count of 0 means rotate forever, so it can never finish.
  assign final_xfer  = end_of_pass & (loops_q != '0) & (pass_inc == loops_q);

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no branch leaves
    // it unassigned; a missing default here would infer a latch.
    state_d = state_q;
    q_d     = q_q;
    valid_d = valid_q;
    pass_d  = pass_q;
    loops_d = loops_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START && !STOP) begin
          loops_d = LOOPS;
          pass_d  = '0;
          q_d     = N'(1);
          valid_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          q_d = {q_q[N-2:0], q_q[N-1]};
          if (end_of_pass) pass_d = pass_inc;
        end
        // Finishing beats pausing when both land on the same edge.
        if (final_xfer) begin
          q_d     = '0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (STOP) begin
          valid_d = 1'b0;
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (STOP) begin
          q_d     = '0;
          state_d = S_IDLE;
        end else if (START) begin
          valid_d = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        q_d     = '0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= '0;
      loops_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      loops_q <= loops_d;
    end
  end

  assign Q     = q_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign PASS  = pass_q;
  assign LAST  = valid_q & q_q[N-1];

endmodule

// File: doc/ring_seq_ctrl.md
# ring_seq_ctrl

Sequencing controller for the one-hot ring/name-display datapath. It generates the one-hot slot pointer `Q[0:N-1]` and advances it only under a valid/ready handshake with the downstream coder/consumer. It supports a programmed number of passes or continuous rotation, plus pause, resume and abort. It replaces the free-running ring, so the display can be started, stalled and stopped under control.

## Interface
- `N`, default 13: number of ring slots; width of `Q`.
- `LOOPS_W`, default 4: width of `LOOPS` and `PASS`.

- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  start a sequence from IDLE, or resume from PAUSE.
- `STOP`  in  1  pause from RUN, or abort from PAUSE.
- `LOOPS`  in  LOOPS_W  number of passes to run; 0 means continuous. Sampled only on START in IDLE.
- `READY`  in  1  consumer accepts the current slot.
- `Q`  out  N  one-hot slot pointer; bit 0 is the first slot; all-zero when not running.
- `VALID`  out  1  `Q` is presented to the consumer.
- `LAST`  out  1  `VALID & Q[N-1]` (combinational).
- `BUSY`  out  1  state is not IDLE.
- `DONE`  out  1  one-cycle pulse when the final pass completes.
- `PASS`  out  LOOPS_W  number of completed passes; wraps modulo 2^LOOPS_W.

## Operation
- **Reset:** while `RST_N`=0 (asynchronous), state=IDLE and `Q`, `VALID`, `BUSY`, `DONE`, `PASS` are all 0. Reset mid-sequence discards the sequence immediately; there is no DONE.
- **Transfer:** a transfer occurs on a rising edge where `VALID & READY`=1.
- **IDLE:** `Q`=0, `VALID`=0.
  - On START: latch `LOOPS`, clear `PASS`, set `Q`=bit 0, set `VALID`=1, go to RUN.
  - STOP is ignored.
  - If START and STOP are both high, STOP wins, so there is no start.
- **RUN:** `VALID`=1.
  - `Q` holds stable while `READY`=0.
  - On a transfer, `Q` rotates to the next bit, with bit N-1 wrapping to bit 0.
  - A transfer at bit N-1 is an end of pass: `PASS` increments.
  - **Final transfer:** an end of pass where the latched LOOPS≠0 and `PASS`+1 == LOOPS. On it: `Q`←0, `VALID`←0, `DONE`←1 for one cycle, go to IDLE.
  - START in RUN is ignored.
- **STOP in RUN:** go to PAUSE with `VALID`←0.
  - If a transfer occurs on the same edge, the transfer completes first: `Q` advances and `PASS` updates.
  - If that transfer is the final transfer, the finish takes priority: DONE pulses and the state goes to IDLE, not PAUSE.
- **PAUSE:** `VALID`=0; `Q` and `PASS` are held.
  - START: back to RUN with `VALID`=1, same `Q`.
  - STOP: abort. `Q`←0 and state goes to IDLE; there is no DONE, and `PASS` keeps its value.
  - STOP wins over START.
- **Continuous mode (LOOPS=0):** never finishes. `PASS` wraps from 2^LOOPS_W−1 to 0. The sequence ends only by a pause followed by an abort, or by reset.
- **Handshake exception:** the usual rule that VALID must not drop before a transfer does not apply to STOP. STOP may withdraw VALID with no transfer. The consumer must tolerate this.
- **Invariant:** `Q` is one-hot when `BUSY`=1 and all-zero when `BUSY`=0.
- **DONE:** never asserts on the same cycle as `VALID`.

## Timing
- All outputs are registered except `LAST`.
- **Start latency:** START sampled at edge k gives `VALID`=1, `Q`=bit 0, `BUSY`=1 after edge k.
- **Throughput:** with `READY` held high, one slot per cycle; one pass = N cycles.
- **Finish:** the final transfer at edge m gives `DONE`=1, `BUSY`=0, `VALID`=0 after edge m. DONE falls after edge m+1.
- **Pause/resume:** each takes effect one edge after STOP or START is sampled.
- **Back-to-back restart:** START may be sampled on the cycle DONE is high, since the state is already IDLE. The new sequence starts after that edge.

## Test plan
1. **Reset mid-run:** assert `RST_N`=0 asynchronously at slot 6 → `Q`=0, `VALID`=0, `BUSY`=0, `PASS`=0 with no clock edge needed. Release reset, then START → `Q`=bit 0.
2. **One pass:** `LOOPS`=1, `READY`=1, START at edge 0.
   - `Q` walks bit 0 through bit 12 over 13 cycles.
   - `LAST`=1 only at bit 12.
   - `DONE`=1 for exactly one cycle after the 13th transfer; `PASS`=1.
3. **Backpressure:** drive `READY`=0 for 3 cycles at slot 5 → `Q` holds bit 5 and `VALID` stays 1. When `READY` returns to 1, the next slot is bit 6 and no slot is skipped.
4. **Pause and abort:**
   - STOP with a transfer at slot 7 → `Q`=bit 8, `VALID`=0, state PAUSE. START → `VALID`=1 at bit 8.
   - Second case: STOP, then STOP again → `Q`=0, IDLE, and no DONE.
5. **Continuous:** `LOOPS`=0, `READY`=1 for 16×13 transfers → `PASS` wraps to 0 and DONE never asserts.
6. **Boundary priorities:**
   - `LOOPS`=2, STOP on the final transfer → DONE pulses, IDLE, `PASS`=2.
   - START+STOP together in IDLE → no start.
